// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter-to-UART transmit path.
package count_uart_pkg;

    // Transmit frame phases; IDLE is the reset state.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clock cycles within one serial bit and pulses
// bit_done on the last cycle of each bit. Held at zero while clear is high.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Count within the bit and wrap at the last cycle so every bit boundary restarts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || (count == LAST_COUNT)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = !clear && (count == LAST_COUNT);

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 serial transmitter for counter values. Accepts one byte per frame via a
// valid/ready handshake (ready gated by ena) and shifts it out LSB first.
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_next;
    logic                 tx_reg;
    logic                 tx_next;
    logic                 baud_clear;
    logic                 bit_done;

    // The baud timer only runs while a frame is in flight, so every frame starts on a fresh bit period.
    assign baud_clear = (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    assign data_ready = (state == IDLE) && ena;
    assign busy       = (state != IDLE);
    assign tx         = tx_reg;

    // Next-state, shift and line-level decisions; the line level is registered so tx changes one cycle after each decision edge.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        tx_next      = tx_reg;
        case (state)
            IDLE: begin
                if (data_valid && data_ready) begin
                    state_next   = START;
                    shift_next   = data_in;
                    bit_idx_next = 3'd0;
                    tx_next      = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // State, payload and line registers; reset forces an idle-high line immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= 3'd0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_idx_next;
            tx_reg    <= tx_next;
        end
    end

endmodule
